// File: rtl/arb_requester_if.sv
// arb_requester_if
//   Bundles the client job handshake, the arbiter request/grant pair and the
//   burst/status outputs of one arb_requester instance.
//   slave  : the requester itself (consumes jobs and grant, drives status)
//   master : the client/arbiter side (drives jobs and grant, observes status)
//
//   Job handshake: job_valid/job_len are offered by the client. A job is
//   transferred on the rising clock edge where job_valid && job_ready are both
//   high. job_ready never depends on job_valid, and a client that raises
//   job_valid keeps it and job_len stable until that transfer edge.
//
//   state_dbg mirrors the requester FSM state:
//   0=IDLE 1=REQ 2=OWN 3=GAP.
interface arb_requester_if #(
  parameter int LEN_W  = 4,
  parameter int QDEPTH = 2
);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic [1:0]       grant;
  logic             req;
  logic             beat;
  logic             last;
  logic             done;
  logic             timeout;
  logic             grant_err;
  logic [CNT_W-1:0] q_count;
  logic [1:0]       state_dbg;

  modport slave (
    input  job_valid, job_len, grant,
    output job_ready, req, beat, last, done, timeout, grant_err, q_count,
           state_dbg
  );

  modport master (
    output job_valid, job_len, grant,
    input  job_ready, req, beat, last, done, timeout, grant_err, q_count,
           state_dbg
  );
endinterface

// File: rtl/arb_requester.sv
// arb_requester
//   Requester-side agent for a two-input grant arbiter. Buffers burst jobs in
//   a small circular queue, raises req, waits for its own grant code, issues
//   job_len+1 beats (one per cycle), then drops req for one GAP cycle.
//   A grant wait longer than TIMEOUT cycles, or the grant vanishing mid-burst,
//   is reported with a one-cycle pulse and the head job is retried.
//
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous active-high reset
//     bus   : arb_requester_if.slave (job handshake, grant/req, beat/last/done,
//             timeout, grant_err, q_count, state_dbg)
module arb_requester #(
  parameter logic [1:0] GRANT_CODE = 2'b10,
  parameter int         LEN_W      = 4,
  parameter int         QDEPTH     = 2,
  parameter int         TIMEOUT    = 15
) (
  input  logic           clock,
  input  logic           reset,
  arb_requester_if.slave bus
);
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OWN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               timeout_q, timeout_d;
  logic [LEN_W-1:0]   mem_q [QDEPTH];
  logic [LEN_W-1:0]   mem_d [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic job_ready;
  logic push;
  logic pop;
  logic granted;
  logic beat;
  logic last;
  logic done;
  logic grant_err;

  // Full means not ready, even if the head is being popped this cycle.
  assign job_ready = (count_q != CNT_W'(QDEPTH));
  assign push      = bus.job_valid && job_ready;
  assign granted   = (bus.grant == GRANT_CODE);

  // Requester FSM: next state and per-cycle outputs.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    beat_cnt_d = beat_cnt_q;
    timeout_d  = 1'b0;
    pop        = 1'b0;
    beat       = 1'b0;
    last       = 1'b0;
    done       = 1'b0;
    grant_err  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (count_q != '0) state_d = S_REQ;
      end
      S_REQ: begin
        wait_d = wait_q + WAIT_W'(1);
        // A grant arriving in the expiry cycle still wins.
        if (granted) begin
          state_d    = S_OWN;
          beat_cnt_d = mem_q[rd_ptr_q];
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
        end
      end
      S_OWN: begin
        // Losing the grant outranks completion; the head stays queued.
        if (!granted) begin
          grant_err = 1'b1;
          state_d   = S_GAP;
        end else begin
          beat       = 1'b1;
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (beat_cnt_q == '0) begin
            last    = 1'b1;
            done    = 1'b1;
            pop     = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Circular job queue; pointers wrap naturally since QDEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.job_len;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  // req is a pure decode of the registered state, so it is glitch-free.
  assign bus.req       = (state_q == S_REQ) || (state_q == S_OWN);
  assign bus.job_ready = job_ready;
  assign bus.beat      = beat;
  assign bus.last      = last;
  assign bus.done      = done;
  assign bus.timeout   = timeout_q;
  assign bus.grant_err = grant_err;
  assign bus.q_count   = count_q;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the two-input grant arbiter: one instance drives arbiter input A, a second instance drives input B.
- Accepts burst jobs from a local client into a small queue.
- Raises and holds its request line, waits for its grant code, issues one beat per cycle for the burst, then releases the request.
- Includes a grant-wait timeout and a grant-loss check, so a stuck or misbehaving arbiter is flagged instead of hanging the client.

Parameters:
GRANT_CODE, 2'b10, grant encoding that means "this requester owns the resource" (2'b10 for side A, 2'b01 for side B)
LEN_W, 4, width of the job length field; burst = job_len+1 beats (1..2^LEN_W)
QDEPTH, 2, job queue depth; power of 2, >=2
TIMEOUT, 15, maximum cycles spent in REQ without a grant before giving up (1..255)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
job_valid  in  1  client offers a job this cycle
job_len  in  LEN_W  burst length minus one
job_ready  out  1  queue not full; a job is accepted on clock edge when job_valid&&job_ready
grant  in  2  arbiter grant output
req  out  1  request to arbiter (registered)
beat  out  1  high in each owned transfer cycle
last  out  1  high with the final beat of a burst
done  out  1  one-cycle pulse, coincident with last
timeout  out  1  one-cycle pulse when grant wait expires
grant_err  out  1  one-cycle pulse when grant leaves GRANT_CODE during OWN
q_count  out  $clog2(QDEPTH)+1  jobs currently queued, including the head job in progress

Behaviour:
- Reset values: state=IDLE; req, beat, last, done, timeout, grant_err = 0; q_count=0; queue pointers 0; job_ready=1.
- Queue is a circular FIFO:
  - job_ready = (q_count != QDEPTH).
  - A push and a pop in the same cycle are legal when not full; q_count is then unchanged.
  - When the queue is full, job_ready=0 even if a pop occurs that cycle.
  - The head entry is popped only on burst completion.
- FSM states: IDLE, REQ, OWN, GAP. req=1 exactly while in REQ or OWN.
- IDLE:
  - q_count!=0 -> REQ at the next edge.
  - Wait counter cleared.
- REQ:
  - Wait counter increments each cycle.
  - grant==GRANT_CODE -> OWN; load the beat counter with head job_len.
  - Otherwise, wait counter reaches TIMEOUT -> pulse timeout, go to GAP; the job is retained at the head and retried.
  - If a grant and the timeout occur in the same cycle, the grant wins.
- OWN:
  - beat=1 every cycle; the beat counter decrements each cycle.
  - When the counter is 0: last=1 and done=1, pop the head, go to GAP.
  - If grant!=GRANT_CODE in any OWN cycle: beat=0 that cycle, pulse grant_err, no pop (the whole burst is retried), go to GAP. This check has priority over completion.
- GAP:
  - req=0 for exactly one cycle, then IDLE.
  - This gives the arbiter one edge to observe the release and return to 00 before any new request.
- Latency with an idle arbiter and empty queue (job accepted at edge E0):
  - req=1 after E1.
  - Arbiter grant visible after E2.
  - First beat in the cycle after E3.
  - An N-beat burst occupies N OWN cycles; req falls at the edge ending the last beat.
- Back-to-back jobs: minimum cycle spacing between bursts = N+1 (GAP) +1 (IDLE) +2 (grant handshake).
- Reset asserted mid-burst: immediate return to IDLE, req=0, queue emptied; in-flight and queued jobs are discarded.
- Pulse outputs (done, timeout, grant_err) are never high for two consecutive cycles from the same event.

Test Plan:
- Single job, job_len=3, arbiter idle -> req rises 1 cycle after accept; beat high for exactly 4 consecutive cycles starting 3 cycles after accept; last/done on the 4th beat; req low at the next cycle; q_count 1->0.
- Two instances (GRANT_CODE 10 and 01) each get job_len=0 in the same cycle -> A gets 1 beat first; B's req is held throughout; B beats only after A's GAP and the arbiter's return to 00; no cycle with both beat outputs high.
- QDEPTH=2: push 3 jobs back-to-back -> job_ready=0 after the second push; third accepted only after the first burst's pop; q_count sequence 1,2,2(stall),1,2...
- Arbiter grant tied to 00, TIMEOUT=15 -> timeout pulses 15 cycles after req rises; req low for one GAP cycle then reasserts; q_count stays 1.
- Force grant to 00 on the 2nd beat of a job_len=5 burst -> grant_err pulse; beat=0 that cycle; no done; burst restarts with 6 full beats after the retry.
- Assert reset asynchronously mid-OWN (between edges) -> req, beat, q_count go to 0 before the next clock edge; job_ready=1; no done pulse.
